// File: rtl/addertest_solver.sv
// Recovers operand b from sum = NUM_A*a + NUM_B*b (mod 2^WIDTH) given a.
// The solver subtracts a NUM_A times, then peels b one bit per cycle from the LSB up.
module addertest_solver #(
    parameter int WIDTH = 32,
    parameter int NUM_A = 6,
    parameter int NUM_B = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy
);

    localparam int CNT_MAX = (WIDTH > NUM_A) ? WIDTH : NUM_A;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]    UNWIND_LAST = CW'(NUM_A - 1);
    localparam logic [CW-1:0]    SOLVE_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] NUM_B_W     = WIDTH'(NUM_B);

    // An even multiplier has no inverse mod 2^WIDTH, so b would not be unique.
    if ((NUM_B % 2) == 0) begin : g_num_b_even
        $error("addertest_solver: NUM_B must be odd");
    end
    if (NUM_A < 1 || NUM_A > 15) begin : g_num_a_range
        $error("addertest_solver: NUM_A must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNWIND = 2'd1,
        SOLVE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  r_q;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     bit_idx;

    assign bit_idx   = cnt[IW-1:0];
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_a     = a_q;
    assign out_b     = b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)            state_next = UNWIND;
            UNWIND:  if (cnt == UNWIND_LAST)  state_next = SOLVE;
            SOLVE:   if (cnt == SOLVE_LAST)   state_next = DONE;
            DONE:    if (out_ready)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        r_q <= in_sum;
                        b_q <= '0;
                        cnt <= '0;
                    end
                end
                UNWIND: begin
                    r_q <= r_q - a_q;
                    cnt <= (cnt == UNWIND_LAST) ? '0 : cnt + 1'b1;
                end
                SOLVE: begin
                    // Lower residue bits are already clear, so bit i decides b[i] alone.
                    if (r_q[bit_idx]) begin
                        b_q[bit_idx] <= 1'b1;
                        r_q          <= r_q - (NUM_B_W << bit_idx);
                    end else begin
                        b_q[bit_idx] <= 1'b0;
                    end
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    assert (r_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addertest_solver.sv
// Bench for addertest_solver: modular-inverse reference model, per-cycle handshake
// and latency checks, plus directed literal vectors and a random sweep.
module tb_addertest_solver;

    localparam int W     = 32;
    localparam int NA    = 6;
    localparam int NB    = 5;
    localparam int LAT   = NA + W + 1;
    localparam int BOUND = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    addertest_solver #(.WIDTH(W), .NUM_A(NA), .NUM_B(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // b = (sum - NA*a) * NB^-1 mod 2^W; Newton iteration doubles the correct bits each step.
    function automatic logic [W-1:0] model_b(input logic [W-1:0] a, input logic [W-1:0] sum);
        logic [W-1:0] x = W'(NB);
        logic [W-1:0] y = W'(NB);
        for (int k = 0; k < 6; k++) y = y * (W'(2) - x * y);
        return (sum - W'(NA) * a) * y;
    endfunction

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b_model;
        logic [W-1:0] b_true;
        logic         has_true;
    } exp_t;

    exp_t          exp_q[$];
    logic          pending = 1'b0;
    int            since_accept = 0;
    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_a, prev_b;
    logic [W-1:0]  cur_b_true = '0;
    logic          cur_has_true = 1'b0;
    int            completions = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pending      = 1'b0;
            since_accept = 0;
            prev_hold    = 1'b0;
        end else begin
            if (pending) since_accept++;
            check("in_ready", W'(in_ready), W'(!pending));
            check("busy", W'(busy), W'(pending));
            check("out_valid", W'(out_valid), W'(pending && since_accept >= LAT));
            if (prev_hold && out_valid) begin
                check("hold_a", out_a, prev_a);
                check("hold_b", out_b, prev_b);
            end
            prev_hold = out_valid && !out_ready;
            prev_a    = out_a;
            prev_b    = out_b;
            if (out_valid && out_ready && pending && exp_q.size() > 0) begin
                check("out_a", out_a, exp_q[0].a);
                check("out_b", out_b, exp_q[0].b_model);
                if (exp_q[0].has_true) check("out_b_true", out_b, exp_q[0].b_true);
                void'(exp_q.pop_front());
                pending = 1'b0;
                completions++;
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{in_a, model_b(in_a, in_sum), cur_b_true, cur_has_true});
                pending      = 1'b1;
                since_accept = 0;
            end
        end
    end

    // Presents one request once the block is idle; returns after the accept edge.
    task automatic submit(input logic [W-1:0] a, input logic [W-1:0] sum);
        int waited = 0;
        while (!in_ready && waited < BOUND) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("submit_timeout", W'(0), W'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_sum   = sum;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Directed run with out_ready high: literal latency and literal result.
    task automatic run_literal(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] sum, input logic [W-1:0] exp_b);
        int lat = 0;
        submit(a, sum);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < BOUND);
        check({name, "_latency"}, W'(lat), W'(39));
        check({name, "_a"}, out_a, a);
        check({name, "_b"}, out_b, exp_b);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", W'(0), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         sweep_done;
        int           n;
        int           start_done;

        #1;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_a", out_a, W'(0));
        check("rst_out_b", out_b, W'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_literal("basic", 32'd1, 32'd11, 32'd1);
        run_literal("zero", 32'd0, 32'd0, 32'd0);
        run_literal("small", 32'd2, 32'd27, 32'd3);
        run_literal("wrap", 32'hFFFF_FFFF, 32'h5B05_B052, 32'h1234_5678);

        // Backpressure with stray requests while busy.
        out_ready = 1'b0;
        submit(32'd7, 32'd7 * 6 + 32'd9 * 5);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_sum = 32'h0BAD_F00D;
        wait_valid();
        check("bp_b_start", out_b, 32'd9);
        repeat (20) begin
            @(posedge clk); #1;
            in_a = $urandom; in_sum = $urandom;
        end
        check("bp_b_end", out_b, 32'd9);
        check("bp_in_ready", W'(in_ready), W'(0));
        in_valid = 1'b0;
        start_done = completions;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_ready", W'(in_ready), W'(1));
        check("bp_one_completion", W'(completions - start_done), W'(1));

        // Asynchronous reset partway through SOLVE.
        submit(32'd2, 32'd27);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", W'(in_ready), W'(1));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_out_a", out_a, W'(0));
        check("mid_rst_out_b", out_b, W'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_literal("after_rst", 32'd2, 32'd27, 32'd3);

        // Random sweep, back-to-back, random consumer backpressure.
        sweep_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 1000; t++) begin
                    ra = $urandom;
                    rb = $urandom;
                    cur_b_true   = rb;
                    cur_has_true = 1'b1;
                    submit(ra, ra * 32'd6 + rb * 32'd5);
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while ((pending || exp_q.size() > 0) && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep_drained", W'(exp_q.size()), W'(0));
        check("total_completions", W'(completions), W'(1006));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
